// File: rtl/bullet_launcher.sv
// Bullet launcher: spawns bullets above the ship on fire, moves them up once per frame,
// and drives the bullet pixel for the VGA mixer. Define BULLET_AUTOFIRE_EN for held-button autofire.
module bullet_launcher #(
  parameter int NUM_BULLETS = 4,
  parameter int SPEED       = 4,
  parameter int COOLDOWN    = 15,
  parameter int SPAWN_Y     = 226
) (
  input  logic                   clk_60hz,
  input  logic                   reset,
  input  logic [9:0]             px,
  input  logic [9:0]             py,
  input  logic                   fire,
  input  logic [9:0]             shipX,
  output logic                   pixel,
  output logic                   fired,
  output logic [NUM_BULLETS-1:0] active
);

  localparam logic [9:0] SPEED_W    = 10'(SPEED);
  localparam logic [7:0] COOLDOWN_W = 8'(COOLDOWN);
  localparam logic [9:0] SPAWN_W    = 10'(SPAWN_Y);

  logic                   fire_prev_q, fire_prev_d;
  logic [7:0]             cooldown_q, cooldown_d;
  logic                   fired_q, fired_d;
  logic [NUM_BULLETS-1:0] active_q, active_d;
  logic [9:0]             x_q [NUM_BULLETS];
  logic [9:0]             x_d [NUM_BULLETS];
  logic [9:0]             y_q [NUM_BULLETS];
  logic [9:0]             y_d [NUM_BULLETS];

  logic                   fire_edge;
  logic                   launch_req;
  logic                   free_found;
  logic                   launch;
  logic [NUM_BULLETS-1:0] free_sel;
  logic                   hit;

  assign fire_edge = fire & ~fire_prev_q;

`ifdef BULLET_AUTOFIRE_EN
  assign launch_req = fire_edge | fire;
`else
  assign launch_req = fire_edge;
`endif

  // Lowest-index free slot, judged on start-of-tick flags so a slot expiring now stays busy.
  always_comb begin
    free_sel   = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active_q[i] && !free_found) begin
        free_sel[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  assign launch = launch_req & (cooldown_q == 8'd0) & free_found;

  always_comb begin
    fire_prev_d = fire;
    fired_d     = launch;
    active_d    = active_q;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (active_q[i]) begin
        if (y_q[i] < SPEED_W) begin
          active_d[i] = 1'b0;
        end else begin
          y_d[i] = y_q[i] - SPEED_W;
        end
      end
      if (launch && free_sel[i]) begin
        active_d[i] = 1'b1;
        x_d[i]      = shipX;
        y_d[i]      = SPAWN_W;
      end
    end
    if (launch) begin
      cooldown_d = COOLDOWN_W;
    end else if (cooldown_q != 8'd0) begin
      cooldown_d = cooldown_q - 8'd1;
    end else begin
      cooldown_d = 8'd0;
    end
  end

  always_ff @(posedge clk_60hz or posedge reset) begin
    if (reset) begin
      fire_prev_q <= 1'b1;
      cooldown_q  <= 8'd0;
      fired_q     <= 1'b0;
      active_q    <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= 10'd0;
        y_q[i] <= 10'd0;
      end
    end else begin
      fire_prev_q <= fire_prev_d;
      cooldown_q  <= cooldown_d;
      fired_q     <= fired_d;
      active_q    <= active_d;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  // 3x7 box around each bullet; 11-bit sums keep the bounds from wrapping near 0.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (active_q[i] &&
          ({1'b0, px} + 11'd1 >= {1'b0, x_q[i]}) &&
          ({1'b0, x_q[i]} + 11'd1 >= {1'b0, px}) &&
          ({1'b0, py} + 11'd3 >= {1'b0, y_q[i]}) &&
          ({1'b0, y_q[i]} + 11'd3 >= {1'b0, py})) begin
        hit = 1'b1;
      end
    end
  end

  assign pixel  = hit;
  assign fired  = fired_q;
  assign active = active_q;

endmodule

// File: tb/tb_bullet_launcher.sv
// Bench for bullet_launcher: two instances (COOLDOWN 15 and 0) against a behavioural slot model.
module tb_bullet_launcher;

  logic       clk_60hz = 1'b0;
  logic       reset;
  logic       fire;
  logic [9:0] px, py, shipX;
  logic       pixel0, fired0, pixel1, fired1;
  logic [3:0] active0, active1;

  int n_checks = 0;
  int n_fail   = 0;

  // model state per instance: [0] COOLDOWN=15, [1] COOLDOWN=0
  bit m_act [2][4];
  int m_x   [2][4];
  int m_y   [2][4];
  int m_cd  [2];
  bit m_prev  [2];
  bit m_fired [2];

  always #5 clk_60hz = ~clk_60hz;

  bullet_launcher #(.NUM_BULLETS(4), .SPEED(4), .COOLDOWN(15), .SPAWN_Y(226)) u_cd15 (
    .clk_60hz(clk_60hz), .reset(reset), .px(px), .py(py), .fire(fire), .shipX(shipX),
    .pixel(pixel0), .fired(fired0), .active(active0)
  );

  bullet_launcher #(.NUM_BULLETS(4), .SPEED(4), .COOLDOWN(0), .SPAWN_Y(226)) u_cd0 (
    .clk_60hz(clk_60hz), .reset(reset), .px(px), .py(py), .fire(fire), .shipX(shipX),
    .pixel(pixel1), .fired(fired1), .active(active1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cd_of(input int k);
    return (k == 0) ? 15 : 0;
  endfunction

  function automatic logic [3:0] m_actvec(input int k);
    logic [3:0] v;
    for (int j = 0; j < 4; j++) v[j] = m_act[k][j];
    return v;
  endfunction

  function automatic logic m_pixel(input int k, input int qx, input int qy);
    for (int j = 0; j < 4; j++) begin
      if (m_act[k][j] && (qx - m_x[k][j] <= 1) && (m_x[k][j] - qx <= 1) &&
          (qy - m_y[k][j] <= 3) && (m_y[k][j] - qy <= 3))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        m_act[k][j] = 0; m_x[k][j] = 0; m_y[k][j] = 0;
      end
      m_cd[k] = 0; m_prev[k] = 1; m_fired[k] = 0;
    end
  endtask

  task automatic model_step(input logic f, input int sx);
    for (int k = 0; k < 2; k++) begin
      bit was_act [4];
      bit req;
      bit launch;
      int sel;
      sel = -1;
      for (int j = 0; j < 4; j++) was_act[j] = m_act[k][j];
      req = f && !m_prev[k];
`ifdef BULLET_AUTOFIRE_EN
      req = f;
`endif
      for (int j = 3; j >= 0; j--) if (!was_act[j]) sel = j;
      launch = req && (m_cd[k] == 0) && (sel >= 0);
      for (int j = 0; j < 4; j++) begin
        if (was_act[j]) begin
          if (m_y[k][j] < 4) m_act[k][j] = 0;
          else m_y[k][j] = m_y[k][j] - 4;
        end
      end
      if (launch) begin
        m_act[k][sel] = 1; m_x[k][sel] = sx; m_y[k][sel] = 226;
        m_cd[k] = cd_of(k);
      end else if (m_cd[k] > 0) begin
        m_cd[k] = m_cd[k] - 1;
      end
      m_fired[k] = launch;
      m_prev[k]  = f;
    end
  endtask

  task automatic probe(input int qx, input int qy);
    if (qx >= 0 && qx < 1024 && qy >= 0 && qy < 1024) begin
      px = 10'(qx); py = 10'(qy);
      #1;
      check("pixel_cd15", 32'(pixel0), 32'(m_pixel(0, qx, qy)));
      check("pixel_cd0",  32'(pixel1), 32'(m_pixel(1, qx, qy)));
    end
  endtask

  // One frame: apply inputs, clock, advance the model, compare flags and a few pixels.
  task automatic tick(input logic f, input int sx);
    fire = f; shipX = 10'(sx);
    @(posedge clk_60hz);
    model_step(f, sx);
    #1;
    check("active_cd15", 32'(active0), 32'(m_actvec(0)));
    check("fired_cd15",  32'(fired0),  32'(m_fired[0]));
    check("active_cd0",  32'(active1), 32'(m_actvec(1)));
    check("fired_cd0",   32'(fired1),  32'(m_fired[1]));
    for (int k = 0; k < 2; k++) begin
      int j;
      j = int'($urandom_range(0, 3));
      if (m_act[k][j])
        probe(m_x[k][j] + int'($urandom_range(0, 4)) - 2, m_y[k][j] + int'($urandom_range(0, 8)) - 4);
    end
    probe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
  endtask

  initial begin
    int sx;
    int rx, ry;
    reset = 1'b1; fire = 1'b1; shipX = 10'd320; px = '0; py = '0;
    model_reset();
    #12;
    check("reset_active_cd15", 32'(active0), 32'h0);
    check("reset_fired_cd15",  32'(fired0),  32'h0);
    check("reset_pixel_cd0",   32'(pixel1),  32'h0);
    reset = 1'b0;

    // fire held through reset release must not launch
    repeat (10) tick(1'b1, 320);
    check("held_no_launch", 32'(active0), 32'h0);
    tick(1'b0, 320);
    tick(1'b1, 320);
    check("first_fired", 32'(fired0), 32'h1);
    check("first_active", 32'(active0), 32'h1);
    probe(321, 229);
    probe(322, 226);
    for (int t = 0; t < 60; t++) tick(1'b0, 320);
    check("flight_expired", 32'(active0), 32'h0);

    // edges 5 ticks apart, then one at 16 ticks after the launch
    for (int t = 0; t <= 20; t++)
      tick((t == 0 || t == 5 || t == 10 || t == 16) ? 1'b1 : 1'b0, int'($urandom_range(12, 628)));
    for (int t = 0; t < 70; t++) tick(1'b0, 400);

    // fill all slots with COOLDOWN 0, then a fire edge on slot0's expiry tick
    for (int t = 0; t <= 70; t++) begin
      sx = int'($urandom_range(12, 628));
      tick((t < 10) ? ((t % 2) == 0) : (t == 57 || t == 59), sx);
      if (t == 8) check("fifth_edge_refused", 32'(fired1), 32'h0);
      if (t == 57) check("expiry_edge_refused", 32'(fired1), 32'h0);
      if (t == 59) check("next_edge_slot0", 32'(active1[0]), 32'h1);
    end

    // asynchronous reset between edges while bullets are in flight
    tick(1'b0, 200);
    tick(1'b1, 200);
    rx = 200; ry = 226;
    for (int j = 0; j < 4; j++) if (m_act[1][j]) begin rx = m_x[1][j]; ry = m_y[1][j]; end
    px = 10'(rx); py = 10'(ry);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_active", 32'(active1), 32'h0);
    check("async_rst_pixel", 32'(pixel1), 32'h0);
    @(negedge clk_60hz);
    reset = 1'b0;

    // held button, then random traffic
    tick(1'b0, 300);
    for (int t = 0; t < 40; t++) tick(1'b1, 300);
    for (int t = 0; t < 400; t++)
      tick(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, int'($urandom_range(12, 628)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
